// File: rtl/ram_host_adapter.sv
// Host front end for a dual-port RAM: zero-fills the array after reset, then
// serves posted writes through a small FIFO and reads through a fixed-latency pipe.
`timescale 1ns/1ps
module ram_host_adapter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hw_valid,
  output logic              hw_ready,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [DATA_W-1:0] hw_data,
  input  logic              hr_valid,
  output logic              hr_ready,
  input  logic [ADDR_W-1:0] hr_addr,
  output logic              hr_rsp_valid,
  output logic [DATA_W-1:0] hr_rsp_data,
  output logic              init_done,
  output logic              wr_enb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_enb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   init_cnt;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic [PTR_W:0]      count;
  logic                fifo_empty, fifo_full;
  logic                push, pop, rd_accept;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic                wr_enb_nxt;
  logic [ADDR_W-1:0]   wr_addr_nxt;
  logic [DATA_W-1:0]   wr_data_nxt;
  logic [RD_LAT-1:0]   vld_p;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign hw_ready   = !fifo_full;
  assign push       = hw_valid & hw_ready;
  // An empty FIFO forwards the incoming write straight to the RAM port.
  assign pop        = (state == RUN) & (!fifo_empty | push);
  assign head_addr  = fifo_empty ? hw_addr : fifo_addr[rptr];
  assign head_data  = fifo_empty ? hw_data : fifo_data[rptr];
  // Reads wait until every accepted write has reached the RAM.
  assign hr_ready   = init_done & fifo_empty & !push;
  assign rd_accept  = hr_valid & hr_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == {ADDR_W{1'b1}}) state_nxt = RUN;
  end

  always_comb begin
    wr_enb_nxt  = 1'b0;
    wr_addr_nxt = '0;
    wr_data_nxt = '0;
    case (state)
      INIT: begin
        wr_enb_nxt  = 1'b1;
        wr_addr_nxt = init_cnt;
        wr_data_nxt = INIT_VAL;
      end
      RUN: begin
        if (pop) begin
          wr_enb_nxt  = 1'b1;
          wr_addr_nxt = head_addr;
          wr_data_nxt = head_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= hw_addr;
      fifo_data[wptr] <= hw_data;
    end
  end

  // Stage p0: registered RAM ports
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_enb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_enb    <= 1'b0;
      rd_addr   <= '0;
      init_done <= 1'b0;
    end else begin
      wr_enb    <= wr_enb_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      rd_enb    <= rd_accept;
      if (rd_accept) rd_addr <= hr_addr;
      init_done <= (state == RUN);
    end
  end

  // Stage p1..pRD_LAT: valid follows the RAM read latency, then data is captured
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p        <= '0;
      hr_rsp_valid <= 1'b0;
      hr_rsp_data  <= '0;
    end else begin
      vld_p[0] <= rd_enb;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      hr_rsp_valid <= vld_p[RD_LAT-1];
      if (vld_p[RD_LAT-1]) hr_rsp_data <= rd_data;
    end
  end

endmodule
